// File: rtl/core_mem_arbiter_if.sv
// Request/response and memory-bus signals around core_mem_arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: bus_ready stalls the bus beat; busy flags tell requesters to hold off.
interface core_mem_arbiter_if #(
    parameter int XLEN = 32
);
    // Instruction-fetch port
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_abort;
    logic [XLEN-1:0]   imem_rdata;
    logic              imem_busy;
    logic              imem_done;
    // Load/store port
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN/8-1:0] dmem_strb;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN-1:0]   dmem_rdata;
    logic              dmem_busy;
    logic              dmem_done;
    // Shared memory bus
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [XLEN/8-1:0] bus_strb;
    logic [XLEN-1:0]   bus_wdata;
    logic [XLEN-1:0]   bus_rdata;

    // Arbiter view
    modport master (
        input  imem_req, imem_addr, imem_abort,
        output imem_rdata, imem_busy, imem_done,
        input  dmem_req, dmem_we, dmem_addr, dmem_strb, dmem_wdata,
        output dmem_rdata, dmem_busy, dmem_done,
        output bus_valid, bus_we, bus_addr, bus_strb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    // Pipeline + memory environment view
    modport slave (
        output imem_req, imem_addr, imem_abort,
        input  imem_rdata, imem_busy, imem_done,
        output dmem_req, dmem_we, dmem_addr, dmem_strb, dmem_wdata,
        input  dmem_rdata, dmem_busy, dmem_done,
        input  bus_valid, bus_we, bus_addr, bus_strb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one single-port memory bus between IMEM fetch and DMEM load/store; optional ARB_ROUND_ROBIN_EN.
// Latency: REQ at N -> bus beat at N+1 -> DONE at N+2 minimum; one idle bus cycle between beats.
// Backpressure: bus beat held stable until bus_ready; ports report busy and ignore new REQs meanwhile.
module core_mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    core_mem_arbiter_if.master mif
);
    localparam int SW = XLEN / 8;
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IMEM_XFER = 2'd1,
        DMEM_XFER = 2'd2
    } state_t;

    state_t          state_q, state_d;

    logic            imem_pend_q, imem_pend_d;
    logic            imem_abort_q, imem_abort_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;

    logic            dmem_pend_q, dmem_pend_d;
    logic            dmem_we_q, dmem_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [SW-1:0]   dmem_strb_q, dmem_strb_d;
    logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;

    logic            bus_valid_q, bus_valid_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [SW-1:0]   bus_strb_q, bus_strb_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;

    logic [XLEN-1:0] imem_rdata_q, imem_rdata_d;
    logic [XLEN-1:0] dmem_rdata_q, dmem_rdata_d;
    logic            imem_done_q, imem_done_d;
    logic            dmem_done_q, dmem_done_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = DMEM was granted last, 0 = IMEM was granted last
    logic            last_dmem_q, last_dmem_d;
`endif

    logic            imem_cap, dmem_cap;
    logic            imem_want, dmem_want, grant_dmem;
    logic [XLEN-1:0] imem_addr_eff;
    logic            dmem_we_eff;
    logic [XLEN-1:0] dmem_addr_eff;
    logic [SW-1:0]   dmem_strb_eff;
    logic [XLEN-1:0] dmem_wdata_eff;

    // Request capture and grant decision; an abort kills a fetch in the same cycle it arrives
    always_comb begin
        imem_cap       = mif.imem_req && !imem_pend_q && !mif.imem_abort;
        dmem_cap       = mif.dmem_req && !dmem_pend_q;
        imem_want      = (imem_pend_q && !mif.imem_abort) || imem_cap;
        dmem_want      = dmem_pend_q || dmem_cap;
        imem_addr_eff  = imem_pend_q ? imem_addr_q  : mif.imem_addr;
        dmem_we_eff    = dmem_pend_q ? dmem_we_q    : mif.dmem_we;
        dmem_addr_eff  = dmem_pend_q ? dmem_addr_q  : mif.dmem_addr;
        dmem_strb_eff  = dmem_pend_q ? dmem_strb_q  : mif.dmem_strb;
        dmem_wdata_eff = dmem_pend_q ? dmem_wdata_q : mif.dmem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
        grant_dmem     = dmem_want && (!imem_want || !last_dmem_q);
`else
        grant_dmem     = dmem_want;
`endif
    end

    // Next-state and registered outputs of the arbitration FSM
    always_comb begin
        state_d      = state_q;
        imem_pend_d  = imem_pend_q;
        imem_abort_d = imem_abort_q;
        imem_addr_d  = imem_addr_q;
        dmem_pend_d  = dmem_pend_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_strb_d  = dmem_strb_q;
        dmem_wdata_d = dmem_wdata_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_strb_d   = bus_strb_q;
        bus_wdata_d  = bus_wdata_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_done_d  = 1'b0;
        dmem_done_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_dmem_d  = last_dmem_q;
`endif

        if (imem_cap) begin
            imem_pend_d = 1'b1;
            imem_addr_d = mif.imem_addr;
        end
        if (dmem_cap) begin
            dmem_pend_d  = 1'b1;
            dmem_we_d    = mif.dmem_we;
            dmem_addr_d  = mif.dmem_addr;
            dmem_strb_d  = mif.dmem_strb;
            dmem_wdata_d = mif.dmem_wdata;
        end
        // A fetch not yet on the bus is simply forgotten on abort
        if (mif.imem_abort && (state_q != IMEM_XFER)) begin
            imem_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_dmem) begin
                    state_d     = DMEM_XFER;
                    bus_valid_d = 1'b1;
                    bus_we_d    = dmem_we_eff;
                    bus_addr_d  = dmem_addr_eff & WORD_MASK;
                    bus_strb_d  = dmem_we_eff ? dmem_strb_eff : '0;
                    bus_wdata_d = dmem_we_eff ? dmem_wdata_eff : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dmem_d = 1'b1;
`endif
                end else if (imem_want) begin
                    state_d     = IMEM_XFER;
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = imem_addr_eff & WORD_MASK;
                    bus_strb_d  = '0;
                    bus_wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dmem_d = 1'b0;
`endif
                end
            end
            IMEM_XFER: begin
                // The beat cannot be withdrawn from the bus; an abort only hides its result
                if (mif.imem_abort) begin
                    imem_abort_d = 1'b1;
                end
                if (mif.bus_ready) begin
                    state_d      = IDLE;
                    bus_valid_d  = 1'b0;
                    imem_pend_d  = 1'b0;
                    imem_abort_d = 1'b0;
                    if (!imem_abort_q && !mif.imem_abort) begin
                        imem_done_d  = 1'b1;
                        imem_rdata_d = mif.bus_rdata;
                    end
                end
            end
            DMEM_XFER: begin
                if (mif.bus_ready) begin
                    state_d     = IDLE;
                    bus_valid_d = 1'b0;
                    dmem_pend_d = 1'b0;
                    dmem_done_d = 1'b1;
                    if (!dmem_we_q) begin
                        dmem_rdata_d = mif.bus_rdata;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // State register with asynchronous clear of every flag and output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            imem_pend_q  <= 1'b0;
            imem_abort_q <= 1'b0;
            imem_addr_q  <= '0;
            dmem_pend_q  <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_strb_q  <= '0;
            dmem_wdata_q <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_strb_q   <= '0;
            bus_wdata_q  <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
            imem_done_q  <= 1'b0;
            dmem_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dmem_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            imem_pend_q  <= imem_pend_d;
            imem_abort_q <= imem_abort_d;
            imem_addr_q  <= imem_addr_d;
            dmem_pend_q  <= dmem_pend_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_strb_q  <= dmem_strb_d;
            dmem_wdata_q <= dmem_wdata_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_strb_q   <= bus_strb_d;
            bus_wdata_q  <= bus_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            imem_done_q  <= imem_done_d;
            dmem_done_q  <= dmem_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dmem_q  <= last_dmem_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // Requests issued while the port is still busy are dropped; make that visible in simulation
    always_ff @(posedge clk) begin
        if (rst_n && mif.imem_req && imem_pend_q && !mif.imem_abort) begin
            $error("core_mem_arbiter: IMEM_REQ while IMEM busy, request ignored");
        end
        if (rst_n && mif.dmem_req && dmem_pend_q) begin
            $error("core_mem_arbiter: DMEM_REQ while DMEM busy, request ignored");
        end
    end
`endif

    assign mif.imem_rdata = imem_rdata_q;
    assign mif.imem_busy  = imem_pend_q;
    assign mif.imem_done  = imem_done_q;
    assign mif.dmem_rdata = dmem_rdata_q;
    assign mif.dmem_busy  = dmem_pend_q;
    assign mif.dmem_done  = dmem_done_q;
    assign mif.bus_valid  = bus_valid_q;
    assign mif.bus_we     = bus_we_q;
    assign mif.bus_addr   = bus_addr_q;
    assign mif.bus_strb   = bus_strb_q;
    assign mif.bus_wdata  = bus_wdata_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: expected completions queued at request time.
// Latency: cycle-exact checks on the directed scenarios, bounded waits on random traffic.
// Backpressure: bus_ready driven per cycle by each scenario (wait states, random stalls).
module tb_core_mem_arbiter;
    localparam int XLEN = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_mem_arbiter_if #(.XLEN(XLEN)) bif ();

    core_mem_arbiter #(.XLEN(XLEN)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (bif.master)
    );

    exp_t        exp_i_q[$];
    exp_t        exp_d_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_irdata = '0;
    logic [31:0] model_drdata = '0;

    // Memory contents: fixed word at 0x104, address-derived pattern elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0104) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    assign bif.bus_rdata = mem_word(bif.bus_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bif.imem_req   = 1'b0;
        bif.imem_addr  = '0;
        bif.imem_abort = 1'b0;
        bif.dmem_req   = 1'b0;
        bif.dmem_we    = 1'b0;
        bif.dmem_addr  = '0;
        bif.dmem_strb  = '0;
        bif.dmem_wdata = '0;
        bif.bus_ready  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.bus_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus got=%b,%b,%h,%h,%h exp=all zero", bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.bus_wdata);
        end
        checks++;
        if ({bif.imem_busy, bif.imem_done, bif.dmem_busy, bif.dmem_done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {bif.imem_busy, bif.imem_done, bif.dmem_busy, bif.dmem_done});
        end
        checks++;
        if ({bif.imem_rdata, bif.dmem_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0", bif.imem_rdata, bif.dmem_rdata);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({bif.bus_valid, bif.imem_busy, bif.dmem_busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release got=%b exp=000", {bif.bus_valid, bif.imem_busy, bif.dmem_busy});
        end
    endtask

    task automatic test_single_fetch();
        exp_t e;
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h0000_0104;
        exp_i_q.push_back('{we: 1'b0, data: 32'h0000_0013});
        step();
        bif.imem_req = 1'b0;
        checks++;
        if ({bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.imem_busy, bif.imem_done} !== {1'b1, 1'b0, 32'h104, 4'h0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fetch_beat got v=%b we=%b a=%h s=%h busy=%b done=%b exp v=1 we=0 a=104 s=0 busy=1 done=0", bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.imem_busy, bif.imem_done);
        end
        bif.bus_ready = 1'b1;
        step();
        bif.bus_ready = 1'b0;
        checks++;
        if ({bif.imem_done, bif.imem_busy, bif.bus_valid} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_done got done/busy/valid=%b exp=100", {bif.imem_done, bif.imem_busy, bif.bus_valid});
        end
        if (bif.imem_done === 1'b1 && exp_i_q.size() > 0) begin
            e = exp_i_q.pop_front();
            model_irdata = e.data;
            checks++;
            if (bif.imem_rdata !== model_irdata) begin
                failures++;
                $display("FAIL fetch_rdata got=%h exp=%h", bif.imem_rdata, model_irdata);
            end
        end
        step();
        checks++;
        if ({bif.imem_done, bif.imem_rdata} !== {1'b0, 32'h0000_0013}) begin
            failures++;
            $display("FAIL fetch_hold got done=%b rdata=%h exp done=0 rdata=00000013", bif.imem_done, bif.imem_rdata);
        end
    endtask

    task automatic test_store_wait();
        exp_t e;
        bif.dmem_req   = 1'b1;
        bif.dmem_we    = 1'b1;
        bif.dmem_addr  = 32'h0000_2003;
        bif.dmem_strb  = 4'b1000;
        bif.dmem_wdata = 32'hAB00_0000;
        exp_d_q.push_back('{we: 1'b1, data: 32'h0});
        step();
        clear_inputs();
        for (int c = 1; c <= 4; c++) begin
            bif.bus_ready = (c == 4);
            checks++;
            if ({bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.bus_wdata, bif.dmem_busy, bif.dmem_done} !== {1'b1, 1'b1, 32'h2000, 4'b1000, 32'hAB00_0000, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL store_hold c%0d got v=%b we=%b a=%h s=%b d=%h busy=%b done=%b exp v=1 we=1 a=2000 s=1000 d=ab000000 busy=1 done=0", c, bif.bus_valid, bif.bus_we, bif.bus_addr, bif.bus_strb, bif.bus_wdata, bif.dmem_busy, bif.dmem_done);
            end
            step();
        end
        bif.bus_ready = 1'b0;
        checks++;
        if ({bif.dmem_done, bif.dmem_busy, bif.bus_valid} !== 3'b100) begin
            failures++;
            $display("FAIL store_done got done/busy/valid=%b exp=100", {bif.dmem_done, bif.dmem_busy, bif.bus_valid});
        end
        if (exp_d_q.size() > 0) begin
            e = exp_d_q.pop_front();
            if (!e.we) model_drdata = e.data;
            checks++;
            if (bif.dmem_rdata !== model_drdata) begin
                failures++;
                $display("FAIL store_rdata got=%h exp=%h", bif.dmem_rdata, model_drdata);
            end
        end
        step();
    endtask

    task automatic test_collision();
        logic dmem_first;
        logic is_d;
        exp_t e;
`ifdef ARB_ROUND_ROBIN_EN
        dmem_first = 1'b0;  // the store before this was the last grant, so IMEM goes first
`else
        dmem_first = 1'b1;
`endif
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h0000_0200;
        bif.dmem_req  = 1'b1;
        bif.dmem_we   = 1'b0;
        bif.dmem_addr = 32'h0000_3001;
        bif.dmem_strb = 4'hF;
        exp_i_q.push_back('{we: 1'b0, data: mem_word(32'h0000_0200)});
        exp_d_q.push_back('{we: 1'b0, data: mem_word(32'h0000_3000)});
        bif.bus_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            is_d = (b == 0) ? dmem_first : !dmem_first;
            step();
            bif.imem_req = 1'b0;
            bif.dmem_req = 1'b0;
            checks++;
            if ({bif.bus_valid, bif.bus_we, bif.bus_addr} !== {1'b1, 1'b0, (is_d ? 32'h3000 : 32'h200)}) begin
                failures++;
                $display("FAIL collide_beat%0d got v=%b we=%b a=%h exp v=1 we=0 a=%h", b, bif.bus_valid, bif.bus_we, bif.bus_addr, (is_d ? 32'h3000 : 32'h200));
            end
            step();
            checks++;
            if ({bif.imem_done, bif.dmem_done, bif.bus_valid} !== {!is_d, is_d, 1'b0}) begin
                failures++;
                $display("FAIL collide_done%0d got idone/ddone/valid=%b exp=%b", b, {bif.imem_done, bif.dmem_done, bif.bus_valid}, {!is_d, is_d, 1'b0});
            end
            if (is_d && exp_d_q.size() > 0) begin
                e = exp_d_q.pop_front();
                model_drdata = e.data;
                checks++;
                if (bif.dmem_rdata !== model_drdata) begin
                    failures++;
                    $display("FAIL collide_drdata got=%h exp=%h", bif.dmem_rdata, model_drdata);
                end
            end else if (!is_d && exp_i_q.size() > 0) begin
                e = exp_i_q.pop_front();
                model_irdata = e.data;
                checks++;
                if (bif.imem_rdata !== model_irdata) begin
                    failures++;
                    $display("FAIL collide_irdata got=%h exp=%h", bif.imem_rdata, model_irdata);
                end
            end
        end
        bif.bus_ready = 1'b0;
        step();
    endtask

    task automatic test_abort_xfer();
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h0000_0400;
        step();
        bif.imem_req = 1'b0;
        checks++;
        if ({bif.bus_valid, bif.bus_addr} !== {1'b1, 32'h400}) begin
            failures++;
            $display("FAIL abort_beat got v=%b a=%h exp v=1 a=400", bif.bus_valid, bif.bus_addr);
        end
        step();
        bif.imem_abort = 1'b1;
        step();
        bif.imem_abort = 1'b0;
        bif.bus_ready  = 1'b1;
        checks++;
        if ({bif.imem_busy, bif.imem_done, bif.bus_valid} !== 3'b101) begin
            failures++;
            $display("FAIL abort_busy got busy/done/valid=%b exp=101", {bif.imem_busy, bif.imem_done, bif.bus_valid});
        end
        step();
        bif.bus_ready = 1'b0;
        checks++;
        if ({bif.imem_done, bif.imem_busy, bif.bus_valid, bif.imem_rdata} !== {3'b000, model_irdata}) begin
            failures++;
            $display("FAIL abort_end got done/busy/valid=%b rdata=%h exp=000 rdata=%h", {bif.imem_done, bif.imem_busy, bif.bus_valid}, bif.imem_rdata, model_irdata);
        end
        step();
        checks++;
        if (bif.imem_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_late_done got=%b exp=0", bif.imem_done);
        end
    endtask

    task automatic test_abort_same_cycle();
        bif.imem_req   = 1'b1;
        bif.imem_abort = 1'b1;
        bif.imem_addr  = 32'h0000_0500;
        step();
        bif.imem_req   = 1'b0;
        bif.imem_abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({bif.bus_valid, bif.imem_busy, bif.imem_done} !== 3'b000) begin
                failures++;
                $display("FAIL abort_req c%0d got valid/busy/done=%b exp=000", c, {bif.bus_valid, bif.imem_busy, bif.imem_done});
            end
            step();
        end
    endtask

    task automatic test_abort_pending();
        exp_t e;
        bif.dmem_req   = 1'b1;
        bif.dmem_we    = 1'b1;
        bif.dmem_addr  = 32'h0000_0010;
        bif.dmem_strb  = 4'hF;
        bif.dmem_wdata = 32'h1122_3344;
        exp_d_q.push_back('{we: 1'b1, data: 32'h0});
        step();
        bif.dmem_req  = 1'b0;
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h0000_0600;
        step();
        bif.imem_req   = 1'b0;
        bif.imem_abort = 1'b1;
        checks++;
        if ({bif.imem_busy, bif.dmem_busy} !== 2'b11) begin
            failures++;
            $display("FAIL pend_busy got i/d busy=%b exp=11", {bif.imem_busy, bif.dmem_busy});
        end
        step();
        bif.imem_abort = 1'b0;
        bif.bus_ready  = 1'b1;
        checks++;
        if (bif.imem_busy !== 1'b0) begin
            failures++;
            $display("FAIL pend_cleared got imem_busy=%b exp=0", bif.imem_busy);
        end
        step();
        bif.bus_ready = 1'b0;
        checks++;
        if (bif.dmem_done !== 1'b1) begin
            failures++;
            $display("FAIL pend_ddone got=%b exp=1", bif.dmem_done);
        end
        if (exp_d_q.size() > 0) e = exp_d_q.pop_front();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({bif.bus_valid, bif.imem_done} !== 2'b00) begin
                failures++;
                $display("FAIL pend_no_fetch c%0d got valid/done=%b exp=00", c, {bif.bus_valid, bif.imem_done});
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bif.dmem_req  = 1'b1;
        bif.dmem_we   = 1'b0;
        bif.dmem_addr = 32'h0000_0040;
        exp_d_q.push_back('{we: 1'b0, data: mem_word(32'h0000_0040)});
        step();
        bif.dmem_req  = 1'b0;
        bif.bus_ready = 1'b1;
        step();
        checks++;
        if ({bif.dmem_done, bif.dmem_busy, bif.bus_valid} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_done1 got done/busy/valid=%b exp=100", {bif.dmem_done, bif.dmem_busy, bif.bus_valid});
        end
        if (exp_d_q.size() > 0) begin
            e = exp_d_q.pop_front();
            model_drdata = e.data;
            checks++;
            if (bif.dmem_rdata !== model_drdata) begin
                failures++;
                $display("FAIL b2b_rdata1 got=%h exp=%h", bif.dmem_rdata, model_drdata);
            end
        end
        bif.dmem_req  = 1'b1;
        bif.dmem_addr = 32'h0000_0080;
        exp_d_q.push_back('{we: 1'b0, data: mem_word(32'h0000_0080)});
        step();
        bif.dmem_req = 1'b0;
        checks++;
        if ({bif.bus_valid, bif.bus_addr, bif.dmem_busy} !== {1'b1, 32'h80, 1'b1}) begin
            failures++;
            $display("FAIL b2b_beat2 got v=%b a=%h busy=%b exp v=1 a=80 busy=1", bif.bus_valid, bif.bus_addr, bif.dmem_busy);
        end
        step();
        bif.bus_ready = 1'b0;
        checks++;
        if (bif.dmem_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done2 got=%b exp=1", bif.dmem_done);
        end
        if (exp_d_q.size() > 0) begin
            e = exp_d_q.pop_front();
            model_drdata = e.data;
            checks++;
            if (bif.dmem_rdata !== model_drdata) begin
                failures++;
                $display("FAIL b2b_rdata2 got=%h exp=%h", bif.dmem_rdata, model_drdata);
            end
        end
        step();
    endtask

    task automatic test_random_traffic();
        exp_t        e;
        logic        is_d;
        logic        done;
        logic [31:0] addr;
        for (int t = 0; t < 10; t++) begin
            is_d = 1'($urandom_range(0, 1));
            addr = $urandom & 32'h0000_FFFF;
            if (is_d) begin
                bif.dmem_req   = 1'b1;
                bif.dmem_we    = 1'($urandom_range(0, 1));
                bif.dmem_addr  = addr;
                bif.dmem_strb  = 4'($urandom_range(1, 15));
                bif.dmem_wdata = $urandom;
                exp_d_q.push_back('{we: bif.dmem_we, data: mem_word(addr & 32'hFFFF_FFFC)});
            end else begin
                bif.imem_req  = 1'b1;
                bif.imem_addr = addr;
                exp_i_q.push_back('{we: 1'b0, data: mem_word(addr & 32'hFFFF_FFFC)});
            end
            step();
            bif.imem_req = 1'b0;
            bif.dmem_req = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (bif.bus_valid === 1'b1) begin
                    checks++;
                    if (bif.bus_addr !== (addr & 32'hFFFF_FFFC)) begin
                        failures++;
                        $display("FAIL rnd_addr t%0d got=%h exp=%h", t, bif.bus_addr, addr & 32'hFFFF_FFFC);
                    end
                end
                bif.bus_ready = 1'($urandom_range(0, 1));
                step();
                if (bif.imem_done === 1'b1 || bif.dmem_done === 1'b1) begin
                    done = 1'b1;
                    checks++;
                    if ({bif.imem_done, bif.dmem_done} !== {!is_d, is_d}) begin
                        failures++;
                        $display("FAIL rnd_port t%0d got idone/ddone=%b exp=%b", t, {bif.imem_done, bif.dmem_done}, {!is_d, is_d});
                    end
                    if (is_d && exp_d_q.size() > 0) begin
                        e = exp_d_q.pop_front();
                        if (!e.we) model_drdata = e.data;
                        checks++;
                        if (bif.dmem_rdata !== model_drdata) begin
                            failures++;
                            $display("FAIL rnd_drdata t%0d got=%h exp=%h", t, bif.dmem_rdata, model_drdata);
                        end
                    end else if (!is_d && exp_i_q.size() > 0) begin
                        e = exp_i_q.pop_front();
                        model_irdata = e.data;
                        checks++;
                        if (bif.imem_rdata !== model_irdata) begin
                            failures++;
                            $display("FAIL rnd_irdata t%0d got=%h exp=%h", t, bif.imem_rdata, model_irdata);
                        end
                    end
                end
            end
            bif.bus_ready = 1'b0;
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL rnd_timeout t%0d got=no DONE in 40 cycles exp=DONE", t);
                exp_i_q.delete();
                exp_d_q.delete();
            end
            step();
        end
    endtask

    task automatic test_reset_mid_beat();
        exp_t e;
        bif.dmem_req   = 1'b1;
        bif.dmem_we    = 1'b1;
        bif.dmem_addr  = 32'h0000_2004;
        bif.dmem_strb  = 4'b0011;
        bif.dmem_wdata = 32'h0000_5555;
        step();
        clear_inputs();
        checks++;
        if ({bif.bus_valid, bif.dmem_busy} !== 2'b11) begin
            failures++;
            $display("FAIL rst_pre got valid/busy=%b exp=11", {bif.bus_valid, bif.dmem_busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bif.bus_valid, bif.dmem_busy, bif.dmem_done, bif.imem_busy, bif.imem_done} !== 5'b00000) begin
            failures++;
            $display("FAIL rst_async got valid/dbusy/ddone/ibusy/idone=%b exp=00000", {bif.bus_valid, bif.dmem_busy, bif.dmem_done, bif.imem_busy, bif.imem_done});
        end
        model_irdata = '0;
        model_drdata = '0;
        exp_i_q.delete();
        exp_d_q.delete();
        step();
        rst_n = 1'b1;
        checks++;
        if ({bif.imem_rdata, bif.dmem_rdata} !== {model_irdata, model_drdata}) begin
            failures++;
            $display("FAIL rst_rdata got=%h/%h exp=%h/%h", bif.imem_rdata, bif.dmem_rdata, model_irdata, model_drdata);
        end
        step();
        bif.dmem_req  = 1'b1;
        bif.dmem_we   = 1'b0;
        bif.dmem_addr = 32'h0000_2008;
        exp_d_q.push_back('{we: 1'b0, data: mem_word(32'h0000_2008)});
        step();
        bif.dmem_req  = 1'b0;
        bif.bus_ready = 1'b1;
        checks++;
        if ({bif.bus_valid, bif.bus_addr} !== {1'b1, 32'h2008}) begin
            failures++;
            $display("FAIL rst_after_beat got v=%b a=%h exp v=1 a=2008", bif.bus_valid, bif.bus_addr);
        end
        step();
        bif.bus_ready = 1'b0;
        checks++;
        if (bif.dmem_done !== 1'b1) begin
            failures++;
            $display("FAIL rst_after_done got=%b exp=1", bif.dmem_done);
        end
        if (exp_d_q.size() > 0) begin
            e = exp_d_q.pop_front();
            model_drdata = e.data;
            checks++;
            if (bif.dmem_rdata !== model_drdata) begin
                failures++;
                $display("FAIL rst_after_rdata got=%h exp=%h", bif.dmem_rdata, model_drdata);
            end
        end
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_collision();
        test_abort_xfer();
        test_abort_same_cycle();
        test_abort_pending();
        test_back_to_back();
        test_random_traffic();
        test_reset_mid_beat();
        checks++;
        if (exp_i_q.size() + exp_d_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d leftover exp=0", exp_i_q.size() + exp_d_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
